// File: rtl/i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_req_arbiter
//
// Shares one i2c_master between NREQ on-chip requesters. Each requester posts a
// single-byte transaction (7-bit address, op, write byte). The arbiter picks an
// owner round-robin, launches the transaction on the master, waits for the
// master to go busy and then done, and returns read data plus NACK/timeout
// status to the owner with a one-cycle response strobe.
//
// Handshake: req[i] is a level. The owner sees gnt[i] from LAUNCH until RESP;
// from then on its fields may change (latched copies are used). rsp_valid[i]
// is a one-cycle strobe; rsp_data/rsp_err/rsp_timeout are valid with it and
// hold until the next response. A requester that keeps req high in the cycle
// after rsp_valid is eligible again, behind the other pending requesters.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req           per-requester request level
//   req_addr      7-bit address per requester, requester i at [7i+6:7i]
//   req_op        1 = read, 0 = write, per requester
//   req_din       write byte per requester, requester i at [8i+7:8i]
//   gnt           one-hot owner of the master
//   rsp_valid     one-cycle response strobe to the owner
//   rsp_data      read byte (0 for writes and timeouts)
//   rsp_err       NACK or timeout
//   rsp_timeout   timeout flag
//   arb_busy      high whenever the sequencer is not idle
//   m_newd/m_addr/m_op/m_din   launch interface to the master
//   m_dout/m_busy/m_ack_err/m_done   status from the master
// -----------------------------------------------------------------------------
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int BUSY_TO = 8,
  parameter int DONE_TO = 16000,
  parameter int TW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [7*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]     req_op,
  input  logic [8*NREQ-1:0]   req_din,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [7:0]          rsp_data,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                arb_busy,
  output logic                m_newd,
  output logic [6:0]          m_addr,
  output logic                m_op,
  output logic [7:0]          m_din,
  input  logic [7:0]          m_dout,
  input  logic                m_busy,
  input  logic                m_ack_err,
  input  logic                m_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [6:0]      addr_q, addr_d;
  logic            op_q, op_d;
  logic [7:0]      din_q, din_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            to_q, to_d;

  // Round-robin search: first asserted request at last+1, last+2, ...
  // wrapping modulo NREQ, so the previous owner has the lowest priority.
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  int            idx;
  logic [IW-1:0] idx_w;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_w      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_q) + k) % NREQ;
      idx_w = IW'(idx);
      if (!pick_found && req[idx_w]) begin
        pick_found = 1'b1;
        pick_idx   = idx_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      din_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    op_d      = op_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    to_d      = to_q;
    m_newd    = 1'b0;
    rsp_valid = '0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          addr_d  = req_addr[7*pick_idx +: 7];
          op_d    = req_op[pick_idx];
          din_d   = req_din[8*pick_idx +: 8];
          gnt_d   = NREQ'(1) << pick_idx;
          state_d = S_LAUNCH;
        end
      end

      // Exactly one newd cycle; a longer pulse would relaunch the master.
      S_LAUNCH: begin
        m_newd  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        if (m_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TW'(BUSY_TO - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // m_done wins over a timeout landing in the same cycle.
      S_WAIT_DONE: begin
        if (m_done) begin
          rdata_d = op_q ? m_dout : 8'h00;
          err_d   = m_ack_err;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TW'(DONE_TO - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        rsp_valid = NREQ'(1) << owner_q;
        last_d    = owner_q;
        gnt_d     = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt         = gnt_q;
  assign rsp_data    = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign arb_busy    = (state_q != S_IDLE);

  // Master-side fields come from the latched copies and read 0 when idle.
  assign m_addr = arb_busy ? addr_q : 7'h00;
  assign m_op   = arb_busy ? op_q   : 1'b0;
  assign m_din  = arb_busy ? din_q  : 8'h00;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_i2c_req_arbiter
//
// Directed bench for i2c_req_arbiter with a cycle-level i2c_master stand-in.
// The master model raises busy two cycles after newd, finishes XFER cycles
// later with a done pulse, NACKs address 7'h7F and returns {1'b0, addr} as
// read data (so slave mem[0x11] = 8'h11). mdl_mode 1 never raises busy,
// mdl_mode 2 raises busy and never signals done.
// -----------------------------------------------------------------------------
module tb_i2c_req_arbiter;

  localparam int NREQ    = 4;
  localparam int BUSY_TO = 8;
  localparam int DONE_TO = 64;
  localparam int TW      = 16;
  localparam int XFER    = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [7*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]     req_op;
  logic [8*NREQ-1:0]   req_din;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [7:0]          rsp_data;
  logic                rsp_err;
  logic                rsp_timeout;
  logic                arb_busy;
  logic                m_newd;
  logic [6:0]          m_addr;
  logic                m_op;
  logic [7:0]          m_din;
  logic [7:0]          m_dout;
  logic                m_busy;
  logic                m_ack_err;
  logic                m_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  i2c_req_arbiter #(
    .NREQ(NREQ), .BUSY_TO(BUSY_TO), .DONE_TO(DONE_TO), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_addr(req_addr), .req_op(req_op), .req_din(req_din),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .arb_busy(arb_busy),
    .m_newd(m_newd), .m_addr(m_addr), .m_op(m_op), .m_din(m_din),
    .m_dout(m_dout), .m_busy(m_busy), .m_ack_err(m_ack_err), .m_done(m_done)
  );

  // ---------------- master model (drives 2 ns after posedge) ----------------
  int         mdl_mode = 0;
  logic       mdl_act;
  int         mdl_cnt;
  logic [6:0] mdl_addr;
  logic       mdl_op;

  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_dout = 8'h00;
    mdl_act = 1'b0; mdl_cnt = 0; mdl_addr = '0; mdl_op = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_done    = 1'b0;
      m_ack_err = 1'b0;
      if (rst) begin
        mdl_act = 1'b0;
        m_busy  = 1'b0;
      end else if (!mdl_act) begin
        if (m_newd) begin
          mdl_act  = 1'b1;
          mdl_cnt  = 0;
          mdl_addr = m_addr;
          mdl_op   = m_op;
        end
      end else begin
        mdl_cnt++;
        if (mdl_mode == 0) begin
          if (mdl_cnt == 2) begin
            m_busy = 1'b1;
          end else if (mdl_cnt == 2 + XFER) begin
            m_busy    = 1'b0;
            m_done    = 1'b1;
            m_ack_err = (mdl_addr == 7'h7F);
            m_dout    = mdl_op ? {1'b0, mdl_addr} : 8'h5A;
            mdl_act   = 1'b0;
          end
        end else begin
          if (mdl_mode == 2 && mdl_cnt == 2) m_busy = 1'b1;
          if (!arb_busy) begin
            m_busy  = 1'b0;
            mdl_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- newd monitor ----------------
  int newd_run   = 0;
  int newd_total = 0;
  int newd_max   = 0;

  always @(negedge clk) begin
    newd_run <= m_newd ? newd_run + 1 : 0;
    if (m_newd) begin
      newd_total <= newd_total + 1;
      if (newd_run + 1 > newd_max) newd_max <= newd_run + 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic o, input logic [7:0] d);
    req_addr[7*i +: 7] = a;
    req_op[i]          = o;
    req_din[8*i +: 8]  = d;
  endtask

  // sel: 0 m_newd, 1 m_done, 2 any rsp_valid, 3 m_busy
  task automatic wait_sig(input string tag, input int sel, input int limit, output int at);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      case (sel)
        0:       ok = m_newd;
        1:       ok = m_done;
        2:       ok = (rsp_valid != '0);
        default: ok = m_busy;
      endcase
      if (ok) break;
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
    at = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] exp_g [5];
  logic [6:0] exp_a [5];
  int t_n, t_r, t_d, n0;
  logic [3:0] rsp_seen;

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_op = '0; req_din = '0;
    do_reset();

    // Reset state
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy_newd", 32'({arb_busy, m_newd}), 32'h0);
    check("rst_m_fields", 32'({m_addr, m_op, m_din}), 32'h0);
    check("rst_rsp_fields", 32'({rsp_data, rsp_err, rsp_timeout}), 32'h0);

    // 1: single write from requester 0
    set_req(0, 7'h20, 1'b0, 8'hA5);
    req = 4'b0001;
    wait_sig("t1_newd", 0, 20, t_n);
    check("t1_m_addr", 32'(m_addr), 32'h20);
    check("t1_m_din", 32'(m_din), 32'hA5);
    check("t1_m_op", 32'(m_op), 32'h0);
    check("t1_gnt", 32'(gnt), 32'h1);
    req = '0;                       // owner may drop/alter once granted
    req_addr = '1;
    req_din  = '1;
    tick();
    check("t1_newd_one_cycle", 32'(m_newd), 32'h0);
    check("t1_m_addr_latched", 32'(m_addr), 32'h20);
    check("t1_m_din_latched", 32'(m_din), 32'hA5);
    wait_sig("t1_done", 1, 60, t_d);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_err", 32'(rsp_err), 32'h0);
    check("t1_rsp_data", 32'(rsp_data), 32'h0);
    check("t1_rsp_timeout", 32'(rsp_timeout), 32'h0);
    tick();
    check("t1_rsp_one_cycle", 32'(rsp_valid), 32'h0);
    check("t1_gnt_clear", 32'(gnt), 32'h0);

    // 2: single read from requester 2
    set_req(2, 7'h11, 1'b1, 8'h00);
    req = 4'b0100;
    wait_sig("t2_rsp", 2, 80, t_r);
    req = '0;
    check("t2_rsp_valid", 32'(rsp_valid), 32'h4);
    check("t2_rsp_data", 32'(rsp_data), 32'h11);
    check("t2_rsp_err", 32'(rsp_err), 32'h0);

    // 3: round-robin with all requesters held high after reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(7'h30 + i), 1'b0, 8'(i));
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_a = '{7'h30, 7'h31, 7'h32, 7'h33, 7'h30};
    n0 = newd_total;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_sig("t3_newd", 0, 20, t_n);
      check("t3_gnt", 32'(gnt), 32'(exp_g[k]));
      check("t3_m_addr", 32'(m_addr), 32'(exp_a[k]));
      wait_sig("t3_rsp", 2, 80, t_r);
      check("t3_rsp_valid", 32'(rsp_valid), 32'(exp_g[k]));
    end
    req = '0;
    tick();
    check("t3_newd_count", 32'(newd_total - n0), 32'd5);
    check("t3_newd_width", 32'(newd_max), 32'd1);

    // 4: NACK on 7'h7F from requester 1, requester 3 waiting behind it
    set_req(1, 7'h7F, 1'b0, 8'h3C);
    set_req(3, 7'h22, 1'b0, 8'h44);
    req = 4'b1010;
    wait_sig("t4_rsp", 2, 80, t_r);
    req[1] = 1'b0;
    check("t4_rsp_valid", 32'(rsp_valid), 32'h2);
    check("t4_rsp_err", 32'(rsp_err), 32'h1);
    check("t4_rsp_timeout", 32'(rsp_timeout), 32'h0);
    wait_sig("t4_newd", 0, 20, t_n);
    check("t4_next_gnt", 32'(gnt), 32'h8);
    wait_sig("t4_rsp2", 2, 80, t_r);
    req = '0;
    check("t4_rsp2_valid", 32'(rsp_valid), 32'h8);
    check("t4_rsp2_err", 32'(rsp_err), 32'h0);

    // 5a: master never goes busy. Counting the newd cycle and the response
    // cycle inclusively: newd, BUSY_TO WAIT_BUSY cycles, RESP = BUSY_TO+2.
    repeat (2) tick();
    mdl_mode = 1;
    set_req(0, 7'h40, 1'b0, 8'h01);
    req = 4'b0001;
    wait_sig("t5_newd", 0, 20, t_n);
    req = '0;
    wait_sig("t5_rsp", 2, 40, t_r);
    check("t5_busy_to_latency", 32'(t_r - t_n + 1), 32'(BUSY_TO + 2));
    check("t5_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t5_rsp_err", 32'(rsp_err), 32'h1);
    check("t5_rsp_timeout", 32'(rsp_timeout), 32'h1);
    check("t5_rsp_data", 32'(rsp_data), 32'h0);
    repeat (3) tick();
    check("t5_hold", 32'({rsp_err, rsp_timeout}), 32'h3);

    // 5b: master busy, never done. newd, two WAIT_BUSY cycles (busy seen in
    // the second), DONE_TO WAIT_DONE cycles, then RESP.
    mdl_mode = 2;
    set_req(1, 7'h41, 1'b1, 8'h00);
    req = 4'b0010;
    wait_sig("t5b_newd", 0, 20, t_n);
    req = '0;
    wait_sig("t5b_rsp", 2, DONE_TO + 40, t_r);
    check("t5b_done_to_latency", 32'(t_r - t_n), 32'(DONE_TO + 3));
    check("t5b_rsp_valid", 32'(rsp_valid), 32'h2);
    check("t5b_flags", 32'({rsp_err, rsp_timeout}), 32'h3);
    check("t5b_rsp_data", 32'(rsp_data), 32'h0);
    repeat (3) tick();
    mdl_mode = 0;

    // 6: reset during WAIT_DONE, then requester 0 wins again
    set_req(2, 7'h11, 1'b1, 8'h00);
    req = 4'b0100;
    wait_sig("t6_newd", 0, 20, t_n);
    req = '0;
    wait_sig("t6_busy", 3, 20, t_d);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_ctrl", 32'({gnt, rsp_valid, arb_busy, m_newd}), 32'h0);
    check("t6_rst_m_fields", 32'({m_addr, m_op, m_din}), 32'h0);
    check("t6_rst_rsp_fields", 32'({rsp_data, rsp_err, rsp_timeout}), 32'h0);
    rsp_seen = '0;
    tick();
    rsp_seen = rsp_seen | rsp_valid;
    rst = 1'b0;
    for (int i = 0; i < 2 * XFER; i++) begin
      tick();
      rsp_seen = rsp_seen | rsp_valid;
    end
    check("t6_no_rsp_after_abort", 32'(rsp_seen), 32'h0);
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(7'h50 + i), 1'b0, 8'hC0);
    req = 4'b1111;
    wait_sig("t6_newd2", 0, 20, t_n);
    check("t6_gnt_after_reset", 32'(gnt), 32'h1);
    wait_sig("t6_rsp2", 2, 80, t_r);
    req = '0;
    check("t6_rsp2_valid", 32'(rsp_valid), 32'h1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
